pending_encoder_32_5: RTL and testbench
=======================================

PENDING_ENCODER_32_5 -- requirements
Module: pending_encoder_32_5

Interface
REQ-001 Parameter MASK_R0, default 1: when 1, bit 0 of set_vec is ignored (register 0 never pending).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 set_en  input  1  qualifies set_vec this cycle.
REQ-005 set_vec  input  32  bits to mark pending (bit n = register n).
REQ-006 ack  input  1  consumer accepts current idx.
REQ-007 valid  output  1  at least one bit pending.
REQ-008 idx  output  5  binary index of lowest-numbered pending bit.
REQ-009 pending  output  32  current pending mask P.
REQ-010 count  output  6  number of set bits in P (0..32).
REQ-011 dup_err  output  1  sticky duplicate-set flag; exists only with PENC_DUPCHK_EN.

Function
REQ-012 Block SHALL hold a 32-bit pending register P; pending = P.
REQ-013 valid SHALL equal OR-reduction of P; idx SHALL be the lowest set bit index of P, 5'd0 when P = 0.
REQ-014 valid, idx, count SHALL be decoded from registered P only (no combinational path from set_en, set_vec or ack).
REQ-015 Handshake: transfer occurs on a rising edge with valid = 1 and ack = 1; bit idx SHALL then clear in P.
REQ-016 ack with valid = 0 SHALL be ignored.
REQ-017 Each edge: P_next = (P & ~clr) | s, where clr = one-hot(idx) if transfer else 0, and s = set_vec (bit 0 forced 0 when MASK_R0 = 1) if set_en else 0.
REQ-018 Simultaneous set and clear of the same bit: set SHALL win; bit remains 1.
REQ-019 Latency: a bit set at edge n SHALL be visible on pending/valid/idx/count after edge n; idx after a transfer SHALL advance to the next pending bit after that edge.
REQ-020 Successive acks SHALL drain bits in ascending index order; a newly set lower bit SHALL pre-empt higher pending bits on the following cycle.
REQ-021 count SHALL be a registered population count updated consistently with P_next (count = popcount(P) at all times).
REQ-022 Full (P = all ones, or all except bit 0 with MASK_R0 = 1): further sets of pending bits SHALL have no effect on P.
REQ-023 Empty: valid = 0, idx = 0, count = 0.

Reset
REQ-024 reset SHALL asynchronously force P = 0, count = 0, dup_err = 0; hence valid = 0, idx = 0.
REQ-025 reset asserted mid-drain SHALL discard all pending bits; an ack or set in the reset-release cycle is ignored until the first edge with reset low.

Configuration
REQ-026 Macro PENC_DUPCHK_EN: when defined, dup_err SHALL be present and set to 1 on any edge where s & P & ~clr is non-zero, holding until reset.
REQ-027 When PENC_DUPCHK_EN is undefined, dup_err port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Reset, then set_en = 1, set_vec = 32'h0000_0014 for one cycle -> next cycle valid = 1, idx = 2, count = 2, pending = 32'h14.
REQ-029 From pending = 32'h14, ack held 2 cycles -> idx 2 then 4, then valid = 0, count = 0.
REQ-030 From pending = 32'h10 (idx = 4), ack = 1 with set_vec = 32'h10 -> pending stays 32'h10, count = 1; with PENC_DUPCHK_EN, dup_err = 0 (bit being cleared); set 32'h10 again without ack -> dup_err = 1.
REQ-031 MASK_R0 = 1, set_vec = 32'hFFFF_FFFF -> pending = 32'hFFFF_FFFE, idx = 1, count = 31; MASK_R0 = 0 -> pending all ones, idx = 0, count = 32.
REQ-032 pending = 32'h8000_0000, set 32'h0000_0008 same cycle as ack -> bit 31 cleared, next idx = 3, count = 1.
REQ-033 Assert reset asynchronously mid-cycle with pending = 32'hF0 -> outputs zero immediately, before next clk edge.

Source files
------------

// File: rtl/pending_encoder_32_5.sv
// pending_encoder_32_5
//   32-entry pending-bit register with a lowest-index-first drain handshake.
//   Set requests are OR-ed into the pending mask P. The consumer acknowledges
//   the current index, which clears that bit. valid, idx and count are kept
//   in flops computed from the next value of P, so no input has a
//   combinational path to any output.
//
//   Optional feature (compile-time macro PENC_DUPCHK_EN):
//     Adds a sticky dup_err output. It is set when a set request hits a bit
//     that is already pending and is not being cleared on that same edge.
//     When the macro is undefined, the port and its logic do not exist.
//
//   Parameter MASK_R0 (default 1): when 1, set_vec[0] is ignored and
//   register 0 never becomes pending.

module pending_encoder_32_5 #(
  parameter bit MASK_R0 = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_en,
  input  logic [31:0] set_vec,
  input  logic        ack,
  output logic        valid,
  output logic [4:0]  idx,
  output logic [31:0] pending,
  output logic [5:0]  count
`ifdef PENC_DUPCHK_EN
  ,
  output logic        dup_err
`endif
);

  // Bits that are allowed to become pending.
  localparam logic [31:0] SET_MASK = MASK_R0 ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;

  logic [31:0] pending_q, pending_d;
  logic [4:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic [5:0]  count_q, count_d;

  logic        transfer;
  logic [31:0] clr_vec;
  logic [31:0] set_bits;

  // The handshake completes only when something is actually pending.
  // clr_vec is the one-hot of the bit being handed to the consumer.
  // set_bits holds the qualified and masked set request for this edge.
  always_comb begin
    transfer = valid_q & ack;
    clr_vec  = 32'd0;
    if (transfer) begin
      clr_vec = 32'd1 << idx_q;
    end
    set_bits = set_en ? (set_vec & SET_MASK) : 32'd0;
  end

  // Next pending mask. The set term is applied after the clear term, so a
  // bit that is set and cleared on the same edge stays pending.
  always_comb begin
    pending_d = (pending_q & ~clr_vec) | set_bits;
  end

  // Decode the next mask into the values the flops will present after the
  // edge: the lowest set index, an any-pending flag and the population count.
  // The loop scans from the top down so that the lowest set bit is written last.
  always_comb begin
    idx_d   = 5'd0;
    valid_d = |pending_d;
    count_d = 6'd0;
    for (int i = 31; i >= 0; i--) begin
      if (pending_d[i]) begin
        idx_d = 5'(i);
      end
    end
    for (int i = 0; i < 32; i++) begin
      count_d = count_d + 6'(pending_d[i]);
    end
  end

  // State register. Reset empties the mask and all decoded outputs at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 32'd0;
      idx_q     <= 5'd0;
      valid_q   <= 1'b0;
      count_q   <= 6'd0;
    end else begin
      pending_q <= pending_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

`ifdef PENC_DUPCHK_EN
  logic dup_err_q, dup_err_d;

  // The flag is sticky. It is raised when a set request targets a bit that is
  // pending and is not being handed off on this edge.
  always_comb begin
    dup_err_d = dup_err_q | (|(set_bits & pending_q & ~clr_vec));
  end

  // Duplicate-error flag register. Only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dup_err_q <= 1'b0;
    end else begin
      dup_err_q <= dup_err_d;
    end
  end

  assign dup_err = dup_err_q;
`endif

  assign pending = pending_q;
  assign valid   = valid_q;
  assign idx     = idx_q;
  assign count   = count_q;

endmodule

// File: tb/tb_pending_encoder_32_5.sv
// Directed testbench for pending_encoder_32_5.
// Instance dut_a uses MASK_R0 = 1 and instance dut_b uses MASK_R0 = 0.
// Both instances receive the same stimulus. Outputs are sampled on the
// falling clock edge.

module tb_pending_encoder_32_5;

  logic        clk = 1'b0;
  logic        reset;
  logic        set_en;
  logic [31:0] set_vec;
  logic        ack;

  logic        valid_a, valid_b;
  logic [4:0]  idx_a, idx_b;
  logic [31:0] pending_a, pending_b;
  logic [5:0]  count_a, count_b;
`ifdef PENC_DUPCHK_EN
  logic        dup_err_a, dup_err_b;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pending_encoder_32_5 #(.MASK_R0(1'b1)) dut_a (
    .clk     (clk),
    .reset   (reset),
    .set_en  (set_en),
    .set_vec (set_vec),
    .ack     (ack),
    .valid   (valid_a),
    .idx     (idx_a),
    .pending (pending_a),
    .count   (count_a)
`ifdef PENC_DUPCHK_EN
    ,
    .dup_err (dup_err_a)
`endif
  );

  pending_encoder_32_5 #(.MASK_R0(1'b0)) dut_b (
    .clk     (clk),
    .reset   (reset),
    .set_en  (set_en),
    .set_vec (set_vec),
    .ack     (ack),
    .valid   (valid_b),
    .idx     (idx_b),
    .pending (pending_b),
    .count   (count_b)
`ifdef PENC_DUPCHK_EN
    ,
    .dup_err (dup_err_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks every output of the MASK_R0 = 1 instance against expected values.
  task automatic check_a(input string tag, input logic [31:0] p, input logic v,
                         input logic [4:0] i, input logic [5:0] c);
    check({tag, " a.pending"}, pending_a, p);
    check({tag, " a.valid"},   {31'd0, valid_a}, {31'd0, v});
    check({tag, " a.idx"},     {27'd0, idx_a}, {27'd0, i});
    check({tag, " a.count"},   {26'd0, count_a}, {26'd0, c});
  endtask

  // Checks every output of the MASK_R0 = 0 instance against expected values.
  task automatic check_b(input string tag, input logic [31:0] p, input logic v,
                         input logic [4:0] i, input logic [5:0] c);
    check({tag, " b.pending"}, pending_b, p);
    check({tag, " b.valid"},   {31'd0, valid_b}, {31'd0, v});
    check({tag, " b.idx"},     {27'd0, idx_b}, {27'd0, i});
    check({tag, " b.count"},   {26'd0, count_b}, {26'd0, c});
  endtask

  // Drives the inputs for one cycle, waits for the rising edge, and returns at
  // the following falling edge. It prints one line per transaction.
  task automatic step(input logic se, input logic [31:0] sv, input logic a);
    set_en  = se;
    set_vec = sv;
    ack     = a;
    @(posedge clk);
    @(negedge clk);
    $display("t=%0t set_en=%0b set_vec=%h ack=%0b | a: p=%h v=%0b i=%0d c=%0d | b: p=%h v=%0b i=%0d c=%0d",
             $time, se, sv, a, pending_a, valid_a, idx_a, count_a,
             pending_b, valid_b, idx_b, count_b);
    set_en  = 1'b0;
    set_vec = 32'd0;
    ack     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    set_en  = 1'b0;
    set_vec = 32'd0;
    ack     = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    check_a("reset", 32'd0, 1'b0, 5'd0, 6'd0);
    check_b("reset", 32'd0, 1'b0, 5'd0, 6'd0);
`ifdef PENC_DUPCHK_EN
    check("reset a.dup_err", {31'd0, dup_err_a}, 32'd0);
`endif

    // Set is ignored while reset is held high.
    set_en = 1'b1; set_vec = 32'h0000_00FF;
    @(posedge clk); @(negedge clk);
    check_a("set_in_reset", 32'd0, 1'b0, 5'd0, 6'd0);
    set_en = 1'b0; set_vec = 32'd0;
    reset = 1'b0;

    // Set 0x14 -> idx 2, count 2.
    step(1'b1, 32'h0000_0014, 1'b0);
    check_a("set14", 32'h14, 1'b1, 5'd2, 6'd2);
    check_b("set14", 32'h14, 1'b1, 5'd2, 6'd2);

    // Drain in ascending order.
    step(1'b0, 32'd0, 1'b1);
    check_a("ack1", 32'h10, 1'b1, 5'd4, 6'd1);
    step(1'b0, 32'd0, 1'b1);
    check_a("ack2", 32'h0, 1'b0, 5'd0, 6'd0);

    // An ack while nothing is pending is ignored.
    step(1'b0, 32'd0, 1'b1);
    check_a("ack_empty", 32'h0, 1'b0, 5'd0, 6'd0);

    // Set wins over clear on the same bit.
    step(1'b1, 32'h0000_0010, 1'b0);
    check_a("set10", 32'h10, 1'b1, 5'd4, 6'd1);
    step(1'b1, 32'h0000_0010, 1'b1);
    check_a("set_clr_same", 32'h10, 1'b1, 5'd4, 6'd1);
`ifdef PENC_DUPCHK_EN
    check("set_clr_same a.dup_err", {31'd0, dup_err_a}, 32'd0);
`endif
    step(1'b1, 32'h0000_0010, 1'b0);
    check_a("dup_set", 32'h10, 1'b1, 5'd4, 6'd1);
`ifdef PENC_DUPCHK_EN
    check("dup_set a.dup_err", {31'd0, dup_err_a}, 32'd1);
    step(1'b0, 32'd0, 1'b0);
    check("dup_sticky a.dup_err", {31'd0, dup_err_a}, 32'd1);
`endif
    step(1'b0, 32'd0, 1'b1);
    check_a("drain10", 32'h0, 1'b0, 5'd0, 6'd0);

    // Full mask, with and without masking of register 0.
    step(1'b1, 32'hFFFF_FFFF, 1'b0);
    check_a("full", 32'hFFFF_FFFE, 1'b1, 5'd1, 6'd31);
    check_b("full", 32'hFFFF_FFFF, 1'b1, 5'd0, 6'd32);
    step(1'b1, 32'hFFFF_FFFF, 1'b0);
    check_a("full_again", 32'hFFFF_FFFE, 1'b1, 5'd1, 6'd31);
    check_b("full_again", 32'hFFFF_FFFF, 1'b1, 5'd0, 6'd32);
    step(1'b0, 32'd0, 1'b1);
    check_a("full_ack", 32'hFFFF_FFFC, 1'b1, 5'd2, 6'd30);
    check_b("full_ack", 32'hFFFF_FFFE, 1'b1, 5'd1, 6'd31);

    // Reset discards pending bits and clears the sticky flag.
    do_reset();
    check_a("reset2", 32'd0, 1'b0, 5'd0, 6'd0);
`ifdef PENC_DUPCHK_EN
    check("reset2 a.dup_err", {31'd0, dup_err_a}, 32'd0);
`endif

    // Bit 31 acknowledged while bit 3 is set on the same edge.
    step(1'b1, 32'h8000_0000, 1'b0);
    check_a("set31", 32'h8000_0000, 1'b1, 5'd31, 6'd1);
    step(1'b1, 32'h0000_0008, 1'b1);
    check_a("ack31_set3", 32'h8, 1'b1, 5'd3, 6'd1);

    // A newly set lower bit pre-empts the higher pending bits.
    step(1'b1, 32'h0000_0300, 1'b0);
    check_a("set300", 32'h308, 1'b1, 5'd3, 6'd3);
    step(1'b1, 32'h0000_0004, 1'b0);
    check_a("preempt", 32'h30C, 1'b1, 5'd2, 6'd4);
    step(1'b0, 32'd0, 1'b1);
    check_a("after_preempt", 32'h308, 1'b1, 5'd3, 6'd3);

    // Asynchronous reset in mid-cycle with pending = 0xF0.
    do_reset();
    step(1'b1, 32'h0000_00F0, 1'b0);
    check_a("setF0", 32'hF0, 1'b1, 5'd4, 6'd4);
    #2;
    reset = 1'b1;
    #1;
    check_a("async_reset", 32'd0, 1'b0, 5'd0, 6'd0);
    check_b("async_reset", 32'd0, 1'b0, 5'd0, 6'd0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 32'd0, 1'b1);
    check_a("post_reset", 32'd0, 1'b0, 5'd0, 6'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
